// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pops a 64x8 synchronous FIFO and presents its bytes as a registered valid/ready stream
module fifo_stream_reader #(
  parameter int BUF_DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             buf_empty,
  input  logic [7:0]       buf_out,
  output logic             rd_en,
  output logic [7:0]       m_data,
  output logic             m_valid,
  input  logic             m_ready,
  output logic [CNT_W-1:0] bytes_sent,
  output logic             busy
);
  logic [7:0] mem [BUF_DEPTH];
  logic [1:0] occ, occ_next;
  logic       inflight, wr_ptr, rd_ptr, rd_ptr_next, pop;
  logic [7:0] head_next;
  assign pop  = m_valid && m_ready;
  assign busy = (occ != 2'd0) || inflight;
  always_comb begin
    occ_next    = occ + {1'b0, inflight} - {1'b0, pop};
    rd_ptr_next = rd_ptr ^ pop;
    // a byte landing in an otherwise empty buffer becomes the head directly
    head_next   = (inflight && wr_ptr == rd_ptr_next) ? buf_out : mem[rd_ptr_next];
    rd_en       = en && !buf_empty && !rst && (occ_next < 2'd2);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      occ        <= 2'd0;
      inflight   <= 1'b0;
      wr_ptr     <= 1'b0;
      rd_ptr     <= 1'b0;
      m_data     <= 8'h00;
      m_valid    <= 1'b0;
      bytes_sent <= '0;
    end else begin
      occ      <= occ_next;
      inflight <= rd_en;
      rd_ptr   <= rd_ptr_next;
      m_valid  <= occ_next != 2'd0;
      if (inflight) begin
        mem[wr_ptr] <= buf_out;
        wr_ptr      <= ~wr_ptr;
      end
      if (occ_next != 2'd0) m_data <= head_next;
      if (pop) bytes_sent <= bytes_sent + 1'b1;
    end
  end
endmodule

// File: tb/tb_fifo_stream_reader.sv
// tb_fifo_stream_reader: emulated FIFO source, in-order scoreboard model and directed scenarios
module tb_fifo_stream_reader;
  logic        clk = 1'b0;
  logic        rst, en, m_ready;
  logic        buf_empty, rd_en, m_valid, busy;
  logic [7:0]  buf_out = 8'h00;
  logic [7:0]  m_data;
  logic [15:0] bytes_sent;

  fifo_stream_reader dut (
    .clk(clk), .rst(rst), .en(en), .buf_empty(buf_empty), .buf_out(buf_out),
    .rd_en(rd_en), .m_data(m_data), .m_valid(m_valid), .m_ready(m_ready),
    .bytes_sent(bytes_sent), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  task automatic chk(input string n, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h at %0t", n, a, e, $time);
    end
  endtask

  // external FIFO: written by the stimulus, drained by the DUT with one-cycle read latency
  logic [7:0] fmem [512];
  int fw = 0;
  int fr = 0;
  int xfers = 0;
  assign buf_empty = (fw == fr);

  always @(posedge clk) begin
    if (rd_en) begin
      buf_out <= fmem[fr];
      fr <= fr + 1;
    end
    if (!rst && m_valid && m_ready) xfers <= xfers + 1;
  end

  task automatic push(input logic [7:0] b);
    fmem[fw] = b;
    fw++;
  endtask

  // model: bytes leave the FIFO in order, land one cycle later, and are delivered in the same order
  logic [7:0]  mq [$];
  bit          pend = 0;
  bit          armed = 0;
  bit          pop_m;
  logic [7:0]  pend_b, md_exp;
  logic [15:0] cnt_m;

  always @(negedge clk) begin
    if (armed) begin
      pop_m = (mq.size() != 0) && m_ready;
      chk("m_valid", m_valid, mq.size() != 0);
      chk("m_data", m_data, md_exp);
      chk("bytes_sent", bytes_sent, cnt_m);
      chk("busy", busy, (mq.size() != 0) || pend);
      chk("rd_en", rd_en, en && !buf_empty && !rst && (int'(mq.size()) + int'(pend) - int'(pop_m) < 2));
      chk("occ_le2", mq.size() <= 2, 1);
      chk("rd_en_empty", rd_en && buf_empty, 0);
    end
    if (rst) begin
      mq.delete();
      pend   = 0;
      md_exp = 8'h00;
      cnt_m  = 16'h0000;
      armed  = 1;
    end else if (armed) begin
      if (pop_m) begin
        md_exp = mq.pop_front();
        cnt_m  = cnt_m + 16'd1;
      end
      if (pend) mq.push_back(pend_b);
      if (mq.size() != 0) md_exp = mq[0];
      pend   = rd_en;
      pend_b = fmem[fr];
    end
  end

  task automatic wait_xfers(input int target, input int bound, input string n);
    int k = 0;
    while (xfers < target && k < bound) begin
      @(negedge clk);
      k++;
    end
    chk(n, xfers, target);
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "timeout");
  end

  initial begin
    logic [7:0] bp [5];
    int f0, x0, k;
    bp = '{8'hAA, 8'hBB, 8'hCC, 8'hDD, 8'hEE};
    rst = 1; en = 1; m_ready = 1;
    repeat (2) @(posedge clk);
    #1 rst = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      chk("idle_rd_en", rd_en, 0);
      chk("idle_m_valid", m_valid, 0);
      chk("idle_m_data", m_data, 8'h00);
      chk("idle_bytes", bytes_sent, 0);
      chk("idle_busy", busy, 0);
    end

    @(posedge clk); #1;
    for (int i = 1; i <= 16; i++) push(8'(i));
    @(negedge clk); chk("lat_rd_en_N", rd_en, 1); chk("lat_valid_N", m_valid, 0);
    @(negedge clk); chk("lat_valid_N1", m_valid, 0);
    for (int i = 0; i < 16; i++) begin
      @(negedge clk);
      chk("stream_valid", m_valid, 1);
      chk("stream_data", m_data, i + 1);
    end
    @(negedge clk);
    chk("stream_bytes", bytes_sent, 16);
    chk("stream_valid_end", m_valid, 0);
    chk("stream_rd_en_end", rd_en, 0);

    @(posedge clk); #1;
    m_ready = 0; f0 = fr;
    for (int i = 0; i < 5; i++) push(bp[i]);
    repeat (8) @(negedge clk);
    chk("bp_pops", fr - f0, 2);
    chk("bp_rd_en", rd_en, 0);
    chk("bp_m_data", m_data, 8'hAA);
    chk("bp_valid", m_valid, 1);
    @(posedge clk); #1;
    m_ready = 1; x0 = xfers;
    @(negedge clk); chk("bp_resume_rd_en", rd_en, 1);
    wait_xfers(x0 + 5, 40, "bp_drain");
    chk("bp_bytes", bytes_sent, 21);

    @(posedge clk); #1;
    x0 = xfers;
    for (int i = 0; i < 64; i++) push(8'(i));
    k = 0;
    while (xfers < x0 + 64 && k < 2000) begin
      m_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      k++;
    end
    m_ready = 1;
    chk("rand_delivered", xfers - x0, 64);

    @(posedge clk); #1;
    f0 = fr; x0 = xfers;
    for (int i = 0; i < 10; i++) push(8'h80 + 8'(i));
    k = 0;
    while (fr - f0 < 3 && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    en = 0;
    repeat (10) @(negedge clk);
    chk("en_pops", fr - f0, 3);
    chk("en_delivered", xfers - x0, 3);
    chk("en_busy", busy, 0);
    @(posedge clk); #1;
    en = 1;
    wait_xfers(x0 + 10, 40, "en_drain");

    @(posedge clk); #1;
    for (int i = 0; i < 8; i++) push(8'hC0 + 8'(i));
    repeat (4) @(posedge clk);
    #1 rst = 1;
    @(negedge clk); chk("rst_rd_en", rd_en, 0);
    @(posedge clk); #1;
    rst = 0; x0 = xfers;
    @(negedge clk);
    chk("rst_m_valid", m_valid, 0);
    chk("rst_bytes", bytes_sent, 0);
    chk("rst_busy", busy, 0);
    k = 0;
    while (!m_valid && k < 10) begin
      @(negedge clk);
      k++;
    end
    chk("rst_resume_byte", m_data, 8'hC4);
    wait_xfers(x0 + 4, 40, "rst_drain");
    @(negedge clk);
    chk("final_busy", busy, 0);
    chk("final_bytes", bytes_sent, 4);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
